// File: rtl/mem_pkg.sv
// Shared definitions for the SPI memory controller: opcodes, frame length,
// FSM state encoding and the byte-order helper used on both data paths.
package mem_pkg;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
    localparam int         FRAME_BITS    = 64;

    typedef enum logic [2:0] {
        IDLE,
        FAULT,
        START,
        SHIFT,
        STOP,
        DONE
    } memctl_state_t;

    // Data bytes travel little-endian on the wire, MSB-first within a byte.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCLK divider: toggles the SCLK level every CLK_DIV enabled cycles and flags
// the cycle whose closing edge makes SCLK rise or fall. Idles low when disabled.
module spi_clkgen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       sclk_q, sclk_d;
    logic       wrap;

    always_comb begin
        wrap   = en_i && (cnt_q == DIV_LAST);
        cnt_d  = 8'd0;
        sclk_d = 1'b0;
        if (en_i) begin
            cnt_d  = wrap ? 8'd0 : cnt_q + 8'd1;
            sclk_d = wrap ? ~sclk_q : sclk_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= 8'd0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o     = sclk_q;
    assign rise_stb_o = wrap && !sclk_q;
    assign fall_stb_o = wrap && sclk_q;

endmodule

// File: rtl/spi_mem_ctrl.sv
// Serial SPI memory controller: turns one mem_ce request into a 64-bit mode-0
// frame (cmd, 24-bit address, 4 data bytes) and reports completion or fault.
module spi_mem_ctrl
    import mem_pkg::*;
#(
    parameter int CLK_DIV = 1,
    parameter int ADDR_W  = 24,
    parameter int CS_HOLD = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_ce,
    input  logic          mem_we,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          mem_busy,
    output logic          mem_valid,
    output logic          access_fault,
    output logic          spi_sclk,
    output logic          spi_cs_n,
    output logic          spi_mosi,
    input  logic          spi_miso,
    output memctl_state_t dbg_state
);

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] HOLD_LAST = 8'(CS_HOLD - 1);
    localparam logic [6:0] BIT_LAST  = 7'(FRAME_BITS - 1);

    memctl_state_t         state_q, state_d;
    logic                  armed_q, armed_d;
    logic                  we_q, we_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [6:0]            bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-2:0] tx_q, tx_d;
    logic [31:0]           rx_q, rx_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  mosi_q, mosi_d;
    logic                  busy_q, valid_q, fault_q, cs_n_q;
    logic                  rise_stb, fall_stb;
    logic [23:0]           addr_field;
    logic [63:0]           frame;

    spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk        (clk),
        .reset      (reset),
        .en_i       (state_q == SHIFT),
        .sclk_o     (spi_sclk),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb)
    );

    // Word-aligned address, zero-extended into the 24-bit address field.
    assign addr_field = 24'(addr[ADDR_W-1:0]) & 24'hFF_FFFC;
    assign frame      = {mem_we ? SPI_CMD_WRITE : SPI_CMD_READ, addr_field,
                         mem_we ? byte_swap(wdata) : 32'h0};

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q | mem_ce;
        we_d      = we_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        mosi_d    = mosi_q;
        case (state_q)
            IDLE: begin
                if (!mem_ce && armed_q) begin
                    armed_d = 1'b0;
                    we_d    = mem_we;
                    if (|addr[31:ADDR_W]) begin
                        state_d = FAULT;
                    end else begin
                        state_d   = START;
                        cnt_d     = 8'd0;
                        bit_cnt_d = 7'd0;
                        tx_d      = frame[FRAME_BITS-2:0];
                        mosi_d    = frame[FRAME_BITS-1];
                    end
                end
            end
            FAULT: state_d = IDLE;
            START: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SHIFT: begin
                if (rise_stb) rx_d = {rx_q[30:0], spi_miso};
                // After the last bit the shifter has drained, so MOSI returns to 0.
                if (fall_stb) begin
                    tx_d      = {tx_q[FRAME_BITS-3:0], 1'b0};
                    mosi_d    = tx_q[FRAME_BITS-2];
                    bit_cnt_d = bit_cnt_q + 7'd1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = STOP;
                        cnt_d   = 8'd0;
                    end
                end
            end
            STOP: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = byte_swap(rx_q);
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            armed_q   <= 1'b1;
            we_q      <= 1'b0;
            cnt_q     <= 8'd0;
            bit_cnt_q <= 7'd0;
            tx_q      <= '0;
            rx_q      <= 32'h0;
            rdata_q   <= 32'h0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            mosi_q    <= mosi_d;
            busy_q    <= (state_d == START) || (state_d == SHIFT) || (state_d == STOP);
            valid_q   <= (state_d == DONE);
            fault_q   <= (state_d == FAULT);
            cs_n_q    <= !((state_d == START) || (state_d == SHIFT));
        end
    end

    assign rdata        = rdata_q;
    assign mem_busy     = busy_q;
    assign mem_valid    = valid_q;
    assign access_fault = fault_q;
    assign spi_cs_n     = cs_n_q;
    assign spi_mosi     = mosi_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl at CLK_DIV=1 and CLK_DIV=3: directed requests push
// expected responses; a monitor per instance pops and checks them on valid/fault.
module tb_spi_mem_ctrl;
    import mem_pkg::*;

    typedef struct packed {
        logic        is_fault;
        logic [63:0] frame;
        logic [31:0] rdata;
        logic [31:0] due;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ce [2];
    logic          we;
    logic [31:0]   addr, wdata;
    logic [31:0]   rdata [2];
    logic          busy [2], valid [2], fault [2];
    logic          sclk [2], cs_n [2], mosi [2], miso [2];
    memctl_state_t dbg [2];
    logic [63:0]   miso_pat [2];
    int unsigned   cyc = 0;
    int            n_cmp = 0;
    int            n_fail = 0;

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_mem_ctrl #(.CLK_DIV(1), .ADDR_W(24), .CS_HOLD(2)) dut1 (
        .clk(clk), .reset(reset), .mem_ce(ce[0]), .mem_we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata[0]), .mem_busy(busy[0]), .mem_valid(valid[0]), .access_fault(fault[0]),
        .spi_sclk(sclk[0]), .spi_cs_n(cs_n[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0]),
        .dbg_state(dbg[0])
    );

    spi_mem_ctrl #(.CLK_DIV(3), .ADDR_W(24), .CS_HOLD(2)) dut3 (
        .clk(clk), .reset(reset), .mem_ce(ce[1]), .mem_we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata[1]), .mem_busy(busy[1]), .mem_valid(valid[1]), .access_fault(fault[1]),
        .spi_sclk(sclk[1]), .spi_cs_n(cs_n[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1]),
        .dbg_state(dbg[1])
    );

    function automatic void check(input string name, input int g,
                                  input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h required %0h (cycle %0d)", name, g, act, req, cyc);
        end
    endfunction

    // Scoreboard: slave model, MOSI capture and response checking per instance
    for (genvar g = 0; g < 2; g++) begin : g_mon
        localparam int BUSY_N = (g == 0) ? 131 : 389;
        logic [EXP_W-1:0] exp_q[$];
        logic [63:0]      mcap = '0;
        int               mbits = 0;
        int               nbusy = 0;
        int               fidx = 0;
        logic             sclk_prev = 1'b0;
        exp_t             e;

        // Mode-0 slave: next bit presented after each SCLK fall, restarted by CS high
        always @(negedge sclk[g] or posedge cs_n[g]) begin
            if (cs_n[g]) fidx <= 0;
            else         fidx <= fidx + 1;
        end
        assign miso[g] = (fidx < 64) ? miso_pat[g][63 - fidx] : 1'b0;

        always @(negedge clk) begin
            if (!reset) begin
                mcap = '0; mbits = 0; nbusy = 0; sclk_prev = 1'b0;
            end else begin
                if (sclk[g] && !sclk_prev && !cs_n[g]) begin
                    mcap = {mcap[62:0], mosi[g]};
                    mbits++;
                end
                sclk_prev = sclk[g];
                if (busy[g]) nbusy++;
                if (valid[g] || fault[g]) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_resp dut%0d: got valid=%b fault=%b required none (cycle %0d)",
                                 g, valid[g], fault[g], cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("fault_flag", g, 64'(fault[g]), 64'(e.is_fault));
                        check("valid_flag", g, 64'(valid[g]), 64'(!e.is_fault));
                        check("resp_cycle", g, 64'(cyc), 64'(e.due));
                        check("busy_at_resp", g, 64'(busy[g]), 64'(0));
                        check("cs_n_at_resp", g, 64'(cs_n[g]), 64'(1));
                        check("busy_cycles", g, 64'(nbusy), e.is_fault ? 64'(0) : 64'(BUSY_N));
                        check("sclk_rises", g, 64'(mbits), e.is_fault ? 64'(0) : 64'(64));
                        if (!e.is_fault) check("mosi_frame", g, mcap, e.frame);
                        check("rdata", g, 64'(rdata[g]), 64'(e.rdata));
                    end
                    mcap = '0; mbits = 0; nbusy = 0;
                end
            end
        end
    end

    function automatic int qsize(input int g);
        return (g == 0) ? g_mon[0].exp_q.size() : g_mon[1].exp_q.size();
    endfunction

    // Driver: issue one request, wait for its response, hold mem_ce low, release
    task automatic issue(input int g, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [63:0] pat, input logic [63:0] frm, input logic [31:0] exp_rd,
                         input logic flt, input int lat, input int hold);
        exp_t e;
        int   t;
        @(negedge clk);
        we = w; addr = a; wdata = d; miso_pat[g] = pat;
        e.is_fault = flt;
        e.frame    = frm;
        e.rdata    = exp_rd;
        e.due      = 32'(cyc) + 32'(lat);
        if (g == 0) g_mon[0].exp_q.push_back(e);
        else        g_mon[1].exp_q.push_back(e);
        ce[g] = 1'b0;
        t = 0;
        while (qsize(g) != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (qsize(g) != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL resp_timeout dut%0d: got no response in %0d cycles, required one", g, t);
            if (g == 0) g_mon[0].exp_q.delete();
            else        g_mon[1].exp_q.delete();
        end
        repeat (hold) @(negedge clk);
        ce[g] = 1'b1;
    endtask

    task automatic check_reset_state(input int g);
        check("rst_cs_n", g, 64'(cs_n[g]), 64'(1));
        check("rst_busy", g, 64'(busy[g]), 64'(0));
        check("rst_valid", g, 64'(valid[g]), 64'(0));
        check("rst_fault", g, 64'(fault[g]), 64'(0));
        check("rst_rdata", g, 64'(rdata[g]), 64'(0));
        check("rst_sclk", g, 64'(sclk[g]), 64'(0));
        check("rst_mosi", g, 64'(mosi[g]), 64'(0));
        check("rst_state", g, 64'(dbg[g]), 64'(IDLE));
    endtask

    initial begin
        ce[0] = 1'b1; ce[1] = 1'b1;
        we = 1'b0; addr = 32'h0; wdata = 32'h0;
        miso_pat[0] = '0; miso_pat[1] = '0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) check_reset_state(g);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Read: frame 03 00 01 04, slave returns 13 00 50 00
        issue(0, 1'b0, 32'h0000_0106, 32'h0, {32'hA5A5_A5A5, 32'h1300_5000},
              64'h0300_0104_0000_0000, 32'h0050_0013, 1'b0, 132, 0);
        // Write: data bytes go out little-endian; MISO is ignored, rdata unchanged
        issue(0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, '1,
              64'h0200_0200_EFBE_ADDE, 32'h0050_0013, 1'b0, 132, 0);
        // Out-of-range addresses: first illegal and all-ones
        issue(0, 1'b0, 32'h0100_0000, 32'h0, '1, 64'h0, 32'h0050_0013, 1'b1, 1, 0);
        issue(0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, '1, 64'h0, 32'h0050_0013, 1'b1, 1, 0);
        // Top legal address with mem_ce held 10 cycles past DONE, then one high cycle
        issue(0, 1'b0, 32'h00FF_FFFF, 32'h0, {32'h0, 32'h7856_3412},
              64'h03FF_FFFC_0000_0000, 32'h1234_5678, 1'b0, 132, 10);
        issue(0, 1'b1, 32'h0000_0003, 32'h0123_4567, '0,
              64'h0200_0000_6745_2301, 32'h1234_5678, 1'b0, 132, 0);
        // CLK_DIV=3 instance
        issue(1, 1'b0, 32'h0000_0106, 32'h0, {32'h5A5A_5A5A, 32'h1300_5000},
              64'h0300_0104_0000_0000, 32'h0050_0013, 1'b0, 390, 0);
        issue(1, 1'b0, 32'h0100_0000, 32'h0, '0, 64'h0, 32'h0050_0013, 1'b1, 1, 0);

        // Reset in the middle of a frame
        @(negedge clk);
        we = 1'b0; addr = 32'h0000_0040; miso_pat[0] = '1;
        ce[0] = 1'b0;
        repeat (40) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_state(0);
        ce[0] = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        issue(0, 1'b0, 32'h0000_0106, 32'h0, {32'h0F0F_0F0F, 32'h1300_5000},
              64'h0300_0104_0000_0000, 32'h0050_0013, 1'b0, 132, 0);
        repeat (20) @(negedge clk);

        for (int g = 0; g < 2; g++) check("queue_empty", g, 64'(qsize(g)), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
